// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = x - y, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flip-flop with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] x_sh_r;
  logic [WIDTH-1:0] y_sh_r;
  logic [WIDTH-1:0] r_sh_r;
  logic             borrow_r;
  logic [CW-1:0]    cnt_r;

  logic             di_s;
  logic             b_next_s;
  logic [WIDTH-1:0] res_s;

  function automatic logic fs_diff(input logic xi, input logic yi, input logic bi);
    return xi ^ yi ^ bi;
  endfunction

  function automatic logic fs_borrow(input logic xi, input logic yi, input logic bi);
    return (~xi & yi) | (~(xi ^ yi) & bi);
  endfunction

  // Full-subtractor cell on the current operand LSBs and the pending borrow
  always_comb begin
    di_s     = fs_diff(x_sh_r[0], y_sh_r[0], borrow_r);
    b_next_s = fs_borrow(x_sh_r[0], y_sh_r[0], borrow_r);
    res_s    = {di_s, r_sh_r[WIDTH-1:1]};
  end

  // Control FSM, operand/result shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      x_sh_r   <= '0;
      y_sh_r   <= '0;
      r_sh_r   <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
      d        <= '0;
      bo       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_sh_r   <= x;
            y_sh_r   <= y;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          x_sh_r   <= {1'b0, x_sh_r[WIDTH-1:1]};
          y_sh_r   <= {1'b0, y_sh_r[WIDTH-1:1]};
          r_sh_r   <= res_s;
          borrow_r <= b_next_s;
          cnt_r    <= cnt_r + CW'(1);
          // d/bo only move on the final bit so they hold the previous result during RUN
          if (cnt_r == LAST_BIT) begin
            d       <= res_s;
            bo      <= b_next_s;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            done    <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, hand-written corner
// sequences and randomized ops, with results checked through a scoreboard queue.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] d;
  logic         bo;
  logic         busy;
  logic         done;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp_d;
    logic         exp_bo;
  } vec_t;

  logic [W:0] sb_q[$];
  int         n_checks;
  int         n_fail;
  int         done_cnt;
  int         accept_cnt;
  logic [W-1:0] hold_d;
  logic         hold_bo;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .d     (d),
    .bo    (bo),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse pops one expected {bo,d}
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got d=%0h bo=%0b expected no done at %0t", d, bo, $time);
      end else begin
        logic [W:0] e;
        e = sb_q.pop_front();
        if ({bo, d} !== e) begin
          n_fail++;
          $display("FAIL result: got bo=%0b d=%0h expected bo=%0b d=%0h at %0t",
                   bo, d, e[W], e[W-1:0], $time);
        end
      end
    end
  end

  // Called just after an accept edge; returns just after the edge that goes back to IDLE
  task automatic wait_done(input logic [W-1:0] ed, input logic ebo, input string tag);
    int k;
    bit seen;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (done) begin
        seen = 1'b1;
      end else begin
        check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
        check({tag, "_d_hold"}, {23'd0, bo, d}, {23'd0, hold_bo, hold_d});
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", tag);
    end else begin
      check({tag, "_latency"}, k, W + 1);
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
      hold_d  = ed;
      hold_bo = ebo;
    end
    @(posedge clk);
    #1;
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic ebo, input string tag);
    x = a;
    y = b;
    start = 1'b1;
    @(posedge clk);
    sb_q.push_back({ebo, ed});
    accept_cnt++;
    #1;
    start = 1'b0;
    x = $urandom;
    y = $urandom;
    wait_done(ed, ebo, tag);
  endtask

  initial begin
    vec_t vecs[6];
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic [W:0]   rr;

    n_checks = 0;
    n_fail = 0;
    done_cnt = 0;
    accept_cnt = 0;
    hold_d = '0;
    hold_bo = 1'b0;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'h0F, 8'h01, 8'h0E, 1'b0};
    vecs[2] = '{8'hAA, 8'h55, 8'h55, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[5] = '{8'h0F, 8'hF0, 8'h1F, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {22'd0, d, bo, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].exp_d, vecs[i].exp_bo, $sformatf("vec%0d", i));
    end

    // start held high with operands changing during RUN/DONE
    x = 8'h10;
    y = 8'h01;
    start = 1'b1;
    @(posedge clk);
    sb_q.push_back({1'b0, 8'h0F});
    accept_cnt++;
    #1;
    x = 8'hFF;
    y = 8'h00;
    wait_done(8'h0F, 1'b0, "hold_start");
    @(posedge clk);
    sb_q.push_back({1'b0, 8'hFF});
    accept_cnt++;
    #1;
    check("hold_reaccept_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done(8'hFF, 1'b0, "hold_second");

    // reset mid-operation at edge 4
    x = 8'hAA;
    y = 8'h55;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {22'd0, d, bo, busy, done}, 32'd0);
    hold_d = '0;
    hold_bo = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("no_done_after_reset", {31'd0, done}, 32'd0);
    end
    @(posedge clk);
    #1;
    run_op(8'h05, 8'h03, 8'h02, 1'b0, "post_reset");

    for (int i = 0; i < 1000; i++) begin
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 7) == 0) ry = rx;
      rr = ref_sub(rx, ry);
      run_op(rx, ry, rr[W-1:0], rr[W], "rand");
    end

    check("done_count", done_cnt, accept_cnt);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
